// File: rtl/burst_mem_responder.sv
// Burst memory responder: serves one 256-bit line per request as four
// 64-bit beats on mem_resp after a programmable access latency, and
// raises a sticky proto_err when the requester breaks the handshake.
module burst_mem_responder #(
    parameter int unsigned S_LINES_LOG2  = 8,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [63:0] mem_wdata,
    output logic [63:0] mem_rdata,
    output logic        mem_resp,
    output logic        proto_err
);

    // Storage is organised as 64-bit words: {line index, beat number}.
    localparam int unsigned WORD_AW = S_LINES_LOG2 + 2;
    localparam logic [7:0]  RD_LAT  = 8'(READ_LATENCY);
    localparam logic [7:0]  WR_LAT  = 8'(WRITE_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST
    } state_e;

    state_e                  state_q;
    logic [S_LINES_LOG2-1:0] idx_q;
    logic                    is_write_q;
    logic [7:0]              lat_q;
    logic [1:0]              beat_q;
    logic [63:0]             rdata_q;
    logic                    resp_q;
    logic                    err_q;

    logic [63:0] mem_q [0:(1 << WORD_AW) - 1];

    logic               hold_ok;
    logic               final_beat;
    logic               wr_en;
    logic [1:0]         rd_beat;
    logic [WORD_AW-1:0] rd_word;
    logic [WORD_AW-1:0] wr_word;

    // Address bits outside the line index are aliased or sub-line and never used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:S_LINES_LOG2+5], mem_addr[4:0]};

    // Handshake check, write strobe and memory word addresses for this cycle.
    always_comb begin
        // NOTE: every signal gets a value on every path, so no latch is inferred.
        hold_ok    = is_write_q ? (mem_write && !mem_read) : (mem_read && !mem_write);
        final_beat = (state_q == ST_BURST) && (beat_q == 2'd3);
        // The final beat's edge is not hold-checked; reset suppresses the write.
        wr_en      = (state_q == ST_BURST) && is_write_q && !rst && (hold_ok || final_beat);
        // Entering the burst loads word 0; inside it the next word is prefetched.
        rd_beat    = (state_q == ST_BURST) ? (beat_q + 2'd1) : 2'd0;
        rd_word    = {idx_q, rd_beat};
        wr_word    = {idx_q, beat_q};
    end

    // Request/latency/burst sequencer with registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            beat_q  <= 2'd0;
            lat_q   <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_read && mem_write) begin
                        err_q <= 1'b1;
                    end else if (mem_read || mem_write) begin
                        idx_q      <= mem_addr[S_LINES_LOG2+4:5];
                        is_write_q <= mem_write;
                        lat_q      <= mem_write ? WR_LAT : RD_LAT;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!hold_ok) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                        lat_q   <= 8'd0;
                    end else if (lat_q == 8'd1) begin
                        state_q <= ST_BURST;
                        resp_q  <= 1'b1;
                        beat_q  <= 2'd0;
                        lat_q   <= 8'd0;
                        rdata_q <= is_write_q ? 64'd0 : mem_q[rd_word];
                    end else begin
                        lat_q <= lat_q - 8'd1;
                    end
                end
                ST_BURST: begin
                    if (final_beat) begin
                        state_q <= ST_IDLE;
                        resp_q  <= 1'b0;
                        rdata_q <= '0;
                        beat_q  <= 2'd0;
                    end else if (!hold_ok) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                        resp_q  <= 1'b0;
                        rdata_q <= '0;
                        beat_q  <= 2'd0;
                    end else begin
                        beat_q  <= beat_q + 2'd1;
                        rdata_q <= is_write_q ? 64'd0 : mem_q[rd_word];
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    resp_q  <= 1'b0;
                    rdata_q <= '0;
                    beat_q  <= 2'd0;
                end
            endcase
        end
    end

    // Line storage: one 64-bit word written at the edge ending each write beat.
    always_ff @(posedge clk) begin
        // NOTE: the memory array is deliberately not reset; contents survive rst.
        if (wr_en) begin
            mem_q[wr_word] <= mem_wdata;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_resp  = resp_q;
    assign proto_err = err_q;

endmodule
